// File: rtl/cmn_pwm_pkg.sv
// cmn_pwm_pkg: shared types and constants for the cmn_pwm command loader.
//   DUTY_WIDTH   width of every duty value
//   NUM_CH       number of PWM duty channels (three motor pairs + brake)
//   CH_*         channel indices as seen on cmd_ch
//   state_e      loader control state
//   clamp_duty   saturate a requested duty to a ceiling
package cmn_pwm_pkg;

  localparam int DUTY_WIDTH = 10;
  localparam int NUM_CH     = 4;

  localparam logic [1:0] CH_MOT01 = 2'd0;
  localparam logic [1:0] CH_MOT23 = 2'd1;
  localparam logic [1:0] CH_MOT45 = 2'd2;
  localparam logic [1:0] CH_BRK   = 2'd3;

  typedef logic [DUTY_WIDTH-1:0] duty_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TRIP = 2'd2
  } state_e;

  function automatic duty_t clamp_duty(input duty_t d, input duty_t mx);
    return (d > mx) ? mx : d;
  endfunction

endpackage

// File: rtl/cmn_pwm_cmd_loader_if.sv
// cmn_pwm_cmd_loader_if: host -> loader duty command channel.
//   cmd_valid   command present
//   cmd_ready   loader accepts when valid && ready
//   cmd_ch      target channel (CH_* in cmn_pwm_pkg)
//   cmd_duty    requested duty
//   cmd_commit  accepted command closes a command set
// master = host side, slave = loader side.
interface cmn_pwm_cmd_loader_if;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_ch;
  cmn_pwm_pkg::duty_t  cmd_duty;
  logic                cmd_commit;

  modport master (output cmd_valid, output cmd_ch, output cmd_duty,
                  output cmd_commit, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_ch, input cmd_duty,
                  input cmd_commit, output cmd_ready);

endinterface

// File: rtl/cmn_duty_slew.sv
// cmn_duty_slew: one slew-limited duty output.
//   clk, reset  system clock, async active-low reset
//   step_i      move one slew step toward tgt_i this cycle
//   zero_i      force the output to 0 (wins over step_i)
//   tgt_i       target duty (already clamped upstream)
//   out_o       registered duty output
// The output jumps straight to the target once it is within SLEW_STEP,
// so it never overshoots and can never wrap below 0 or above the target.
module cmn_duty_slew
  import cmn_pwm_pkg::*;
#(
  parameter int SLEW_STEP = 16
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  step_i,
  input  logic  zero_i,
  input  duty_t tgt_i,
  output duty_t out_o
);

  typedef logic [DUTY_WIDTH:0] dwx_t;

  localparam dwx_t  STEP_X = dwx_t'(SLEW_STEP);
  localparam duty_t STEP   = duty_t'(SLEW_STEP);

  duty_t out_q, out_d;
  dwx_t  diff, mag;

  // one extra bit so the sign of target - out is visible
  assign diff = {1'b0, tgt_i} - {1'b0, out_q};
  assign mag  = diff[DUTY_WIDTH] ? (dwx_t'(0) - diff) : diff;

  always_comb begin
    out_d = out_q;
    if (zero_i) begin
      out_d = '0;
    end else if (step_i) begin
      if (mag <= STEP_X)          out_d = tgt_i;
      else if (diff[DUTY_WIDTH])  out_d = out_q - STEP;
      else                        out_d = out_q + STEP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_q <= '0;
    else        out_q <= out_d;
  end

  assign out_o = out_q;

endmodule

// File: rtl/cmn_pwm_cmd_loader.sv
// cmn_pwm_cmd_loader: shadow/commit duty loader in front of cmn_pwm.
//   clk, reset          system clock, async active-low reset
//   cmd                 host command channel (slave side)
//   start_pwm_period    1-cycle PWM period boundary strobe
//   pulse_200us         1-cycle watchdog timebase tick
//   mot_en_req          host motor enable request (level)
//   brk_en_req          host brake enable request (level)
//   mot_pwm_param01/23/45, brk_pwm_param   slewed duties to cmn_pwm
//   mot_en_in, brk_en_in                    enables to cmn_pwm
//   wdog_fault          sticky watchdog trip flag
//   clamp_evt           1-cycle pulse: an accepted duty was clamped
// Commands land in shadows; a commit marks the set pending and the whole
// set moves to the targets at the next period strobe. Outputs step toward
// targets once per period. A missing commit for WDOG_TICKS ticks trips the
// loader, which ramps everything to zero before dropping the enables.
module cmn_pwm_cmd_loader
  import cmn_pwm_pkg::*;
#(
  parameter duty_t DUTY_MAX   = 10'h3E0,
  parameter int    SLEW_STEP  = 16,
  parameter int    WDOG_TICKS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  cmn_pwm_cmd_loader_if.slave  cmd,
  input  logic                 start_pwm_period,
  input  logic                 pulse_200us,
  input  logic                 mot_en_req,
  input  logic                 brk_en_req,
  output duty_t                mot_pwm_param01,
  output duty_t                mot_pwm_param23,
  output duty_t                mot_pwm_param45,
  output duty_t                brk_pwm_param,
  output logic                 mot_en_in,
  output logic                 brk_en_in,
  output logic                 wdog_fault,
  output logic                 clamp_evt
);

  localparam int WCW = 8;

  state_e                          state_q, state_d;
  logic [NUM_CH-1:0][DUTY_WIDTH-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0][DUTY_WIDTH-1:0] tgt_q, tgt_d;
  logic [NUM_CH-1:0][DUTY_WIDTH-1:0] duty_out;
  logic                            pending_q, pending_d;
  logic [WCW-1:0]                  wcnt_q, wcnt_d;
  logic                            mot_en_q, mot_en_d;
  logic                            brk_en_q, brk_en_d;
  logic                            fault_q, fault_d;
  logic                            clamp_q, clamp_d;
  logic                            step, zero;
  logic                            accept, any_req, all_zero, wd_hit;

  // strobe cycles refuse writes so a shadow update never races a transfer
  assign cmd.cmd_ready = !start_pwm_period && (state_q != TRIP);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign any_req       = mot_en_req || brk_en_req;
  assign all_zero      = (duty_out == '0);
  assign wd_hit        = (WDOG_TICKS > 0) && (int'(wcnt_q) >= WDOG_TICKS);

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    tgt_d     = tgt_q;
    pending_d = pending_q;
    wcnt_d    = wcnt_q;
    mot_en_d  = mot_en_q;
    brk_en_d  = brk_en_q;
    fault_d   = fault_q;
    clamp_d   = 1'b0;
    step      = 1'b0;
    zero      = 1'b0;

    if (accept) begin
      shadow_d[cmd.cmd_ch] = clamp_duty(cmd.cmd_duty, DUTY_MAX);
      clamp_d              = (cmd.cmd_duty > DUTY_MAX);
      if (cmd.cmd_commit) pending_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        // shadows and pending stay live so the host can preload a set
        zero     = 1'b1;
        tgt_d    = '0;
        wcnt_d   = '0;
        mot_en_d = 1'b0;
        brk_en_d = 1'b0;
        if (any_req) begin
          state_d  = RUN;
          mot_en_d = mot_en_req;
          brk_en_d = brk_en_req;
        end
      end

      RUN: begin
        if (!any_req) begin
          state_d   = IDLE;
          zero      = 1'b1;
          tgt_d     = '0;
          pending_d = 1'b0;
          wcnt_d    = '0;
          mot_en_d  = 1'b0;
          brk_en_d  = 1'b0;
        end else begin
          mot_en_d = mot_en_req;
          brk_en_d = brk_en_req;
          step     = start_pwm_period;
          // a commit beats a coincident tick
          if (accept && cmd.cmd_commit)            wcnt_d = '0;
          else if (pulse_200us && wcnt_q != '1)    wcnt_d = wcnt_q + WCW'(1);
          // the slews see tgt_d, so a transfer steps in the same edge
          if (start_pwm_period && pending_q) begin
            tgt_d     = shadow_q;
            pending_d = 1'b0;
          end
          if (wd_hit) begin
            state_d   = TRIP;
            fault_d   = 1'b1;
            tgt_d     = '0;
            pending_d = 1'b0;
          end
        end
      end

      TRIP: begin
        tgt_d     = '0;
        pending_d = 1'b0;
        wcnt_d    = '0;
        step      = start_pwm_period;
        // enables hold through the ramp and drop once it has finished
        if (all_zero) begin
          mot_en_d = 1'b0;
          brk_en_d = 1'b0;
        end
        if (!any_req) begin
          state_d  = IDLE;
          zero     = 1'b1;
          mot_en_d = 1'b0;
          brk_en_d = 1'b0;
          fault_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      tgt_q     <= '0;
      pending_q <= 1'b0;
      wcnt_q    <= '0;
      mot_en_q  <= 1'b0;
      brk_en_q  <= 1'b0;
      fault_q   <= 1'b0;
      clamp_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      tgt_q     <= tgt_d;
      pending_q <= pending_d;
      wcnt_q    <= wcnt_d;
      mot_en_q  <= mot_en_d;
      brk_en_q  <= brk_en_d;
      fault_q   <= fault_d;
      clamp_q   <= clamp_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cmn_duty_slew #(.SLEW_STEP(SLEW_STEP)) u_slew (
      .clk    (clk),
      .reset  (reset),
      .step_i (step),
      .zero_i (zero),
      .tgt_i  (tgt_d[i]),
      .out_o  (duty_out[i])
    );
  end

  assign mot_pwm_param01 = duty_out[CH_MOT01];
  assign mot_pwm_param23 = duty_out[CH_MOT23];
  assign mot_pwm_param45 = duty_out[CH_MOT45];
  assign brk_pwm_param   = duty_out[CH_BRK];
  assign mot_en_in       = mot_en_q;
  assign brk_en_in       = brk_en_q;
  assign wdog_fault      = fault_q;
  assign clamp_evt       = clamp_q;

endmodule

// File: tb/tb_cmn_pwm_cmd_loader.sv
// Self-checking bench for cmn_pwm_cmd_loader: a table of single-cycle
// handshake/clamp vectors, directed multi-cycle sequences, and a random
// phase, all shadowed by a behavioural model compared every cycle.
module tb_cmn_pwm_cmd_loader;

  localparam int PER  = 20;
  localparam int DMAX = 'h3E0;
  localparam int STEP = 16;
  localparam int WDOG = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic strb = 1'b0, pulse = 1'b0, mreq = 1'b0, breq = 1'b0;
  logic [9:0] p01, p23, p45, pbrk;
  logic men, ben, flt, clmp;

  int total = 0;
  int bad   = 0;

  cmn_pwm_cmd_loader_if cif ();

  cmn_pwm_cmd_loader dut (
    .clk              (clk),
    .reset            (rst_n),
    .cmd              (cif),
    .start_pwm_period (strb),
    .pulse_200us      (pulse),
    .mot_en_req       (mreq),
    .brk_en_req       (breq),
    .mot_pwm_param01  (p01),
    .mot_pwm_param23  (p23),
    .mot_pwm_param45  (p45),
    .brk_pwm_param    (pbrk),
    .mot_en_in        (men),
    .brk_en_in        (ben),
    .wdog_fault       (flt),
    .clamp_evt        (clmp)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 running, 2 tripped
  int m_mode, m_cnt;
  int m_sh[4], m_tg[4], m_out[4];
  bit m_pend, m_men, m_ben, m_flt, m_clmp;

  function automatic int toward(int o, int t);
    if (t > o) return (t - o > STEP) ? o + STEP : t;
    return (o - t > STEP) ? o - STEP : t;
  endfunction

  function automatic bit m_ready();
    return !strb && (m_mode != 2);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_pend = 0;
    m_men = 0; m_ben = 0; m_flt = 0; m_clmp = 0;
    for (int i = 0; i < 4; i++) begin m_sh[i] = 0; m_tg[i] = 0; m_out[i] = 0; end
  endtask

  task automatic model_edge();
    bit acc, anyr, allz, cmt;
    int ch, duty, old_cnt;
    acc  = cif.cmd_valid && m_ready();
    cmt  = acc && cif.cmd_commit;
    anyr = mreq || breq;
    allz = (m_out[0] == 0) && (m_out[1] == 0) && (m_out[2] == 0) && (m_out[3] == 0);
    ch   = int'(cif.cmd_ch);
    duty = int'(cif.cmd_duty);
    old_cnt = m_cnt;
    m_clmp = acc && (duty > DMAX);
    if (acc) m_sh[ch] = (duty > DMAX) ? DMAX : duty;
    if (cmt) m_pend = 1;
    case (m_mode)
      0: begin
        for (int i = 0; i < 4; i++) begin m_out[i] = 0; m_tg[i] = 0; end
        m_cnt = 0;
        m_men = anyr && mreq;
        m_ben = anyr && breq;
        if (anyr) m_mode = 1;
      end
      1: begin
        if (!anyr) begin
          m_mode = 0; m_pend = 0; m_cnt = 0; m_men = 0; m_ben = 0;
          for (int i = 0; i < 4; i++) begin m_out[i] = 0; m_tg[i] = 0; end
        end else begin
          m_men = mreq; m_ben = breq;
          if (cmt) m_cnt = 0;
          else if (pulse && m_cnt < 255) m_cnt++;
          if (strb && m_pend) begin m_tg = m_sh; m_pend = 0; end
          if (WDOG > 0 && old_cnt >= WDOG) begin
            m_mode = 2; m_flt = 1; m_pend = 0;
            for (int i = 0; i < 4; i++) m_tg[i] = 0;
          end
          if (strb) for (int i = 0; i < 4; i++) m_out[i] = toward(m_out[i], m_tg[i]);
        end
      end
      default: begin
        m_pend = 0; m_cnt = 0;
        for (int i = 0; i < 4; i++) m_tg[i] = 0;
        if (strb) for (int i = 0; i < 4; i++) m_out[i] = toward(m_out[i], 0);
        if (allz) begin m_men = 0; m_ben = 0; end
        if (!anyr) begin
          m_mode = 0; m_men = 0; m_ben = 0; m_flt = 0;
          for (int i = 0; i < 4; i++) m_out[i] = 0;
        end
      end
    endcase
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("m_p01",  32'(p01),  32'(m_out[0]));
    chk("m_p23",  32'(p23),  32'(m_out[1]));
    chk("m_p45",  32'(p45),  32'(m_out[2]));
    chk("m_pbrk", 32'(pbrk), 32'(m_out[3]));
    chk("m_men",  32'(men),  32'(m_men));
    chk("m_ben",  32'(ben),  32'(m_ben));
    chk("m_flt",  32'(flt),  32'(m_flt));
    chk("m_clmp", 32'(clmp), 32'(m_clmp));
  endtask

  // inputs must be settled when called; returns 1 time unit after posedge
  task automatic tick();
    #1;
    chk("m_ready", 32'(cif.cmd_ready), 32'(m_ready()));
    model_edge();
    @(posedge clk); #1;
    cmp_model();
  endtask

  task automatic send(input logic [1:0] ch, input logic [9:0] duty, input logic cm);
    cif.cmd_valid = 1'b1; cif.cmd_ch = ch; cif.cmd_duty = duty; cif.cmd_commit = cm;
    tick();
    cif.cmd_valid = 1'b0; cif.cmd_commit = 1'b0;
  endtask

  task automatic strobe(input int gap);
    repeat (gap - 1) tick();
    strb = 1'b1;
    #1;
    chk("ready_in_strobe", 32'(cif.cmd_ready), 32'd0);
    tick();
    strb = 1'b0;
  endtask

  typedef struct {
    logic       strb;
    logic [1:0] ch;
    logic [9:0] duty;
    logic       exp_rdy;
    logic       exp_clamp;
  } vec_t;

  vec_t vt[9];

  initial begin
    vt[0] = '{1'b0, 2'd0, 10'h3E0, 1'b1, 1'b0};
    vt[1] = '{1'b0, 2'd1, 10'h3E1, 1'b1, 1'b1};
    vt[2] = '{1'b0, 2'd2, 10'h3FF, 1'b1, 1'b1};
    vt[3] = '{1'b1, 2'd3, 10'h3FF, 1'b0, 1'b0};
    vt[4] = '{1'b0, 2'd3, 10'h000, 1'b1, 1'b0};
    vt[5] = '{1'b0, 2'd0, 10'h000, 1'b1, 1'b0};
    vt[6] = '{1'b0, 2'd1, 10'h000, 1'b1, 1'b0};
    vt[7] = '{1'b0, 2'd2, 10'h000, 1'b1, 1'b0};
    vt[8] = '{1'b0, 2'd1, 10'h001, 1'b1, 1'b0};

    cif.cmd_valid = 1'b0; cif.cmd_ch = 2'd0; cif.cmd_duty = '0; cif.cmd_commit = 1'b0;
    model_reset();

    // reset state
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_model();
    chk("rst_p01", 32'(p01), 32'd0);
    rst_n = 1'b1;

    // table: handshake and clamp flag while idle (shadows end at small values)
    for (int i = 0; i < 9; i++) begin
      strb = vt[i].strb;
      cif.cmd_valid = 1'b1; cif.cmd_ch = vt[i].ch; cif.cmd_duty = vt[i].duty;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(cif.cmd_ready), 32'(vt[i].exp_rdy));
      tick();
      chk($sformatf("vec%0d_clamp", i), 32'(clmp), 32'(vt[i].exp_clamp));
      strb = 1'b0; cif.cmd_valid = 1'b0;
    end
    send(2'd1, 10'h000, 1'b0);

    // ramp up ch0 and brake
    mreq = 1'b1; breq = 1'b1;
    tick(); tick();
    send(2'd0, 10'h100, 1'b0);
    send(2'd3, 10'h050, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      strobe(PER);
      chk($sformatf("ramp01_k%0d", k), 32'(p01), 32'((16 * k < 256) ? 16 * k : 256));
      chk($sformatf("rampbrk_k%0d", k), 32'(pbrk), 32'((16 * k < 80) ? 16 * k : 80));
    end

    // clamped write on ch1
    send(2'd1, 10'h3FF, 1'b1);
    chk("clamp_pulse", 32'(clmp), 32'd1);
    tick();
    chk("clamp_once", 32'(clmp), 32'd0);
    for (int k = 1; k <= 62; k++) begin
      strobe(PER);
      chk($sformatf("ramp23_k%0d", k), 32'(p23), 32'((16 * k < 992) ? 16 * k : 992));
    end
    strobe(PER);
    chk("p23_settled", 32'(p23), 32'h3E0);

    // uncommitted write must not reach the output
    send(2'd2, 10'h080, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      strobe(PER);
      chk($sformatf("nocommit45_k%0d", k), 32'(p45), 32'd0);
    end
    send(2'd2, 10'h080, 1'b1);
    strobe(PER);
    chk("commit45_first", 32'(p45), 32'h010);
    repeat (7) strobe(PER);
    chk("commit45_done", 32'(p45), 32'h080);

    // watchdog trip after WDOG ticks without a commit
    for (int k = 0; k < WDOG; k++) begin
      pulse = 1'b1; tick(); pulse = 1'b0; tick();
    end
    chk("wdog_fault_set", 32'(flt), 32'd1);
    chk("wdog_ready_low", 32'(cif.cmd_ready), 32'd0);
    send(2'd0, 10'h3FF, 1'b1);
    tick();
    chk("trip_refuse_clamp", 32'(clmp), 32'd0);
    for (int n = 1; n <= 62; n++) begin
      strobe(PER);
      chk($sformatf("trip01_n%0d", n), 32'(p01), 32'((256 - 16 * n > 0) ? 256 - 16 * n : 0));
      chk($sformatf("trip_men_n%0d", n), 32'(men), 32'd1);
    end
    chk("trip_all_zero", 32'({p01, p23, p45, pbrk}), 32'd0);
    tick();
    chk("trip_men_drop", 32'(men), 32'd0);
    chk("trip_ben_drop", 32'(ben), 32'd0);
    chk("trip_fault_held", 32'(flt), 32'd1);
    mreq = 1'b0; breq = 1'b0;
    tick();
    chk("fault_clear", 32'(flt), 32'd0);

    // disable mid-ramp
    mreq = 1'b1;
    tick();
    send(2'd0, 10'h100, 1'b1);
    repeat (8) strobe(PER);
    chk("mid_p01", 32'(p01), 32'h080);
    mreq = 1'b0;
    tick();
    chk("dis_params", 32'({p01, p23, p45, pbrk}), 32'd0);
    chk("dis_men", 32'(men), 32'd0);
    chk("dis_ben", 32'(ben), 32'd0);

    // random phase; odd blocks starve commits so the watchdog gets exercised
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 59) == 0) mreq = ~mreq;
      if ($urandom_range(0, 59) == 0) breq = ~breq;
      strb  = ($urandom_range(0, 7) == 0);
      pulse = ($urandom_range(0, 5) == 0);
      cif.cmd_valid  = 1'($urandom_range(0, 1));
      cif.cmd_ch     = 2'($urandom_range(0, 3));
      cif.cmd_duty   = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(980, 1023))
                                                   : 10'($urandom_range(0, 1023));
      cif.cmd_commit = ((c / 500) % 2 == 0) && ($urandom_range(0, 2) == 0);
      tick();
    end
    strb = 1'b0; pulse = 1'b0; cif.cmd_valid = 1'b0; cif.cmd_commit = 1'b0;

    // async reset in the middle of a ramp
    mreq = 1'b0; breq = 1'b0;
    tick(); tick();
    mreq = 1'b1;
    tick();
    send(2'd0, 10'h200, 1'b1);
    repeat (4) strobe(PER);
    chk("pre_rst_p01", 32'(p01), 32'h040);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_params", 32'({p01, p23, p45, pbrk}), 32'd0);
    chk("arst_en", 32'({men, ben}), 32'd0);
    chk("arst_fault", 32'(flt), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
